// File: rtl/axi_slave_pkg.sv
// Shared constants, FSM state types and the read beat record for the AXI4
// block-RAM responder.
package axi_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_8B     = 3'd3;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    // One read beat as it travels through the output skid buffer.
    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [1:0]  resp;
    } rbeat_t;

endpackage

// File: rtl/sdp_ram_bytewe.sv
// Simple dual-port RAM: byte-enabled write port, registered read port.
// Read-first: a same-cycle read of the word being written returns the old value.
module sdp_ram_bytewe #(
    parameter int WIDTH      = 64,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic [WIDTH/8-1:0]      we,
    input  logic [DEPTH_LOG2-1:0]   waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    re,
    input  logic [DEPTH_LOG2-1:0]   raddr,
    output logic [WIDTH-1:0]        rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        for (int b = 0; b < WIDTH / 8; b++) begin
            if (we[b]) begin
                mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_slave_ram.sv
// AXI4 slave backed by block RAM: INCR bursts up to 256 beats, one outstanding
// burst per direction, independent read and write engines.
module axi_slave_ram
    import axi_slave_pkg::*;
#(
    parameter int DATA_BITS      = 64,
    parameter int ADDR_BITS      = 32,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int ID_BITS        = 1
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic [ID_BITS-1:0]     S_AXI_AWID,
    input  logic [ADDR_BITS-1:0]   S_AXI_AWADDR,
    input  logic [7:0]             S_AXI_AWLEN,
    input  logic [2:0]             S_AXI_AWSIZE,
    input  logic [1:0]             S_AXI_AWBURST,
    input  logic                   S_AXI_AWVALID,
    output logic                   S_AXI_AWREADY,
    input  logic [DATA_BITS-1:0]   S_AXI_WDATA,
    input  logic [DATA_BITS/8-1:0] S_AXI_WSTRB,
    input  logic                   S_AXI_WLAST,
    input  logic                   S_AXI_WVALID,
    output logic                   S_AXI_WREADY,
    output logic [ID_BITS-1:0]     S_AXI_BID,
    output logic [1:0]             S_AXI_BRESP,
    output logic                   S_AXI_BVALID,
    input  logic                   S_AXI_BREADY,
    input  logic [ID_BITS-1:0]     S_AXI_ARID,
    input  logic [ADDR_BITS-1:0]   S_AXI_ARADDR,
    input  logic [7:0]             S_AXI_ARLEN,
    input  logic [2:0]             S_AXI_ARSIZE,
    input  logic [1:0]             S_AXI_ARBURST,
    input  logic                   S_AXI_ARVALID,
    output logic                   S_AXI_ARREADY,
    output logic [ID_BITS-1:0]     S_AXI_RID,
    output logic [DATA_BITS-1:0]   S_AXI_RDATA,
    output logic [1:0]             S_AXI_RRESP,
    output logic                   S_AXI_RLAST,
    output logic                   S_AXI_RVALID,
    input  logic                   S_AXI_RREADY
);

    // Handshake rule on every channel: a transfer occurs on the ACLK edge where
    // VALID and READY are both 1; a raised VALID and its payload hold until then.

    logic unused_addr_bits;
    assign unused_addr_bits = ^{S_AXI_AWADDR[ADDR_BITS-1:MEM_DEPTH_LOG2+3], S_AXI_AWADDR[2:0],
                                S_AXI_ARADDR[ADDR_BITS-1:MEM_DEPTH_LOG2+3], S_AXI_ARADDR[2:0]};

    // ---------------- write engine ----------------
    w_state_t                  w_state, w_next;
    logic                      awready_q, wready_q, bvalid_q;
    logic [1:0]                bresp_q;
    logic [ID_BITS-1:0]        bid_q;
    logic [MEM_DEPTH_LOG2-1:0] w_idx;
    logic [7:0]                w_len, w_cnt;
    logic                      w_cfg_err, w_len_err;
    logic                      aw_hs, w_hs, aw_err;
    logic [DATA_BITS/8-1:0]    ram_we;

    assign aw_hs  = S_AXI_AWVALID && awready_q;
    assign w_hs   = S_AXI_WVALID && wready_q;
    assign aw_err = (S_AXI_AWBURST != BURST_INCR) || (S_AXI_AWSIZE != SIZE_8B);
    // Unsupported burst shapes still consume their data but never touch memory.
    assign ram_we = (w_hs && !w_cfg_err) ? S_AXI_WSTRB : '0;

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && S_AXI_WLAST) w_next = W_RESP;
            W_RESP:  if (S_AXI_BREADY) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
            w_idx     <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_cfg_err <= 1'b0;
            w_len_err <= 1'b0;
        end else begin
            w_state   <= w_next;
            awready_q <= (w_next == W_IDLE);
            wready_q  <= (w_next == W_DATA);
            bvalid_q  <= (w_next == W_RESP);
            if (aw_hs) begin
                bid_q     <= S_AXI_AWID;
                w_idx     <= S_AXI_AWADDR[MEM_DEPTH_LOG2+2:3];
                w_len     <= S_AXI_AWLEN;
                w_cnt     <= '0;
                w_cfg_err <= aw_err;
                w_len_err <= 1'b0;
            end
            if (w_hs) begin
                w_idx <= w_idx + 1'b1;
                w_cnt <= w_cnt + 1'b1;
                // WLAST must coincide exactly with beat AWLEN+1; overruns stay flagged.
                if (S_AXI_WLAST != (w_cnt == w_len)) w_len_err <= 1'b1;
                if (S_AXI_WLAST) begin
                    bresp_q <= (w_cfg_err || w_len_err || (w_cnt != w_len)) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_BID     = bid_q;

    // ---------------- read engine ----------------
    r_state_t                  r_state, r_next;
    logic                      arready_q;
    logic [ID_BITS-1:0]        r_id;
    logic [MEM_DEPTH_LOG2-1:0] r_idx, ram_raddr;
    logic [7:0]                r_rem;
    logic                      r_err, ar_hs, ar_err;
    logic                      ram_re, issue_last, pend_v, pend_last;
    logic                      out_v, sk_v, pop, space;
    logic [1:0]                occ;
    logic [DATA_BITS-1:0]      ram_rdata;
    rbeat_t                    out_q, sk_q, in_beat;

    assign ar_hs  = S_AXI_ARVALID && arready_q;
    assign ar_err = (S_AXI_ARBURST != BURST_INCR) || (S_AXI_ARSIZE != SIZE_8B);
    assign pop    = out_v && S_AXI_RREADY;

    // The first RAM read is issued in the AR handshake cycle itself so the
    // first beat reaches the output register two cycles after the handshake.
    always_comb begin
        occ        = {1'b0, out_v} + {1'b0, sk_v} + {1'b0, pend_v};
        space      = (occ - {1'b0, pop}) <= 2'd1;
        ram_re     = ar_hs || ((r_state == R_DATA) && (r_rem != 8'd0) && space);
        ram_raddr  = (r_state == R_IDLE) ? S_AXI_ARADDR[MEM_DEPTH_LOG2+2:3] : r_idx;
        issue_last = (r_state == R_IDLE) ? (S_AXI_ARLEN == 8'd0) : (r_rem == 8'd1);
        in_beat.data = r_err ? 64'd0 : ram_rdata;
        in_beat.last = pend_last;
        in_beat.resp = r_err ? RESP_SLVERR : RESP_OKAY;
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (pop && out_q.last) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            r_id      <= '0;
            r_idx     <= '0;
            r_rem     <= '0;
            r_err     <= 1'b0;
            pend_v    <= 1'b0;
            pend_last <= 1'b0;
            out_v     <= 1'b0;
            out_q     <= '0;
            sk_v      <= 1'b0;
            sk_q      <= '0;
        end else begin
            r_state   <= r_next;
            arready_q <= (r_next == R_IDLE);
            pend_v    <= ram_re;
            pend_last <= issue_last;
            if (ar_hs) begin
                r_id  <= S_AXI_ARID;
                r_idx <= S_AXI_ARADDR[MEM_DEPTH_LOG2+2:3] + 1'b1;
                r_rem <= S_AXI_ARLEN;
                r_err <= ar_err;
            end else if (ram_re) begin
                r_idx <= r_idx + 1'b1;
                r_rem <= r_rem - 1'b1;
            end
            // Output register refills from the skid entry first, then the RAM.
            if (!out_v || pop) begin
                if (sk_v) begin
                    out_q <= sk_q;
                    out_v <= 1'b1;
                    sk_v  <= pend_v;
                    sk_q  <= in_beat;
                end else begin
                    out_v <= pend_v;
                    if (pend_v) out_q <= in_beat;
                    else        out_q.last <= 1'b0;
                end
            end else if (pend_v) begin
                sk_v <= 1'b1;
                sk_q <= in_beat;
            end
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RID     = r_id;
    assign S_AXI_RDATA   = out_q.data;
    assign S_AXI_RRESP   = out_q.resp;
    assign S_AXI_RLAST   = out_q.last;
    assign S_AXI_RVALID  = out_v;

    sdp_ram_bytewe #(
        .WIDTH      (DATA_BITS),
        .DEPTH_LOG2 (MEM_DEPTH_LOG2)
    ) u_ram (
        .clk   (ACLK),
        .we    (ram_we),
        .waddr (w_idx),
        .wdata (S_AXI_WDATA),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_axi_slave_ram.sv
// Self-checking bench for axi_slave_ram: byte-lane memory model plus an
// expected-beat queue filled when a read is issued and drained on R handshakes.
module tb_axi_slave_ram;

    localparam int DEPTH = 1024;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [0:0]  awid = '0, bid, arid = '0, rid;
    logic [31:0] awaddr = '0, araddr = '0;
    logic [7:0]  awlen = '0, arlen = '0, wstrb = '0;
    logic [2:0]  awsize = '0, arsize = '0;
    logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
    logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
    logic        bvalid, bready = 1'b0, arvalid = 1'b0, arready;
    logic        rlast, rvalid, rready = 1'b0;
    logic [63:0] wdata = '0, rdata;

    logic [63:0] model [DEPTH];
    logic [63:0] exp_q [$];
    logic [63:0] wdata_buf [256];
    logic [7:0]  wstrb_buf [256];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 aclk = ~aclk;

    axi_slave_ram dut (
        .ACLK(aclk), .ARESETN(aresetn),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
        .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready), .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready), .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic write_burst(input logic [31:0] addr, input int len, input int nbeats,
                               input logic [1:0] burst, input logic [2:0] size,
                               input logic id, input bit gaps);
        int         t;
        int         idx;
        bit         ok;
        logic [1:0] exp_resp;
        ok       = (burst == 2'b01) && (size == 3'd3);
        exp_resp = (ok && nbeats == len + 1) ? 2'b00 : 2'b10;
        awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awid = id; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin tick(); t++; end
        check("awready", awready, 1);
        tick();
        awvalid = 1'b0;
        check("wready_after_aw", wready, 1);
        idx = int'(addr[12:3]);
        for (int i = 0; i < nbeats; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) tick();
            end
            wdata = wdata_buf[i]; wstrb = wstrb_buf[i]; wlast = (i == nbeats - 1); wvalid = 1'b1;
            t = 0;
            while (!wready && t < 50) begin tick(); t++; end
            tick();
            wvalid = 1'b0; wlast = 1'b0;
            if (ok) begin
                for (int b = 0; b < 8; b++)
                    if (wstrb_buf[i][b]) model[idx][b*8 +: 8] = wdata_buf[i][b*8 +: 8];
            end
            idx = (idx + 1) % DEPTH;
        end
        check("bvalid_after_wlast", bvalid, 1);
        check("wready_after_wlast", wready, 0);
        check("bresp", bresp, exp_resp);
        check("bid", bid, id);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("awready_after_b", awready, 1);
        check("bvalid_clear", bvalid, 0);
    endtask

    task automatic read_burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                              input logic [1:0] burst, input logic id, input bit slow,
                              input int abort_at);
        int          t, idx, cyc, beats, first;
        bit          ok, stalled;
        logic [63:0] held, e;
        logic [1:0]  exp_resp;
        ok       = (burst == 2'b01) && (size == 3'd3);
        exp_resp = ok ? 2'b00 : 2'b10;
        idx      = int'(addr[12:3]);
        for (int i = 0; i <= len; i++) exp_q.push_back(ok ? model[(idx + i) % DEPTH] : 64'd0);
        araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin tick(); t++; end
        check("arready", arready, 1);
        tick();
        arvalid = 1'b0;
        cyc = 1; beats = 0; first = -1; stalled = 1'b0; held = '0;
        while (beats <= len && cyc < 4000) begin
            rready = slow ? (cyc % 3 == 0) : 1'b1;
            if (stalled) begin
                check("r_hold_valid", rvalid, 1);
                check("r_hold_data", rdata, held);
            end
            if (rvalid && first < 0) first = cyc;
            if (abort_at > 0 && beats == abort_at && rvalid) begin
                aresetn = 1'b0;
                #1;
                check("rvalid_on_reset", rvalid, 0);
                check("rlast_on_reset", rlast, 0);
                exp_q.delete();
                rready = 1'b0;
                return;
            end
            if (rvalid && rready) begin
                e = exp_q.pop_front();
                check("rdata", rdata, e);
                check("rresp", rresp, exp_resp);
                check("rlast", rlast, (beats == len));
                check("rid", rid, id);
                beats++;
            end
            stalled = rvalid && !rready;
            held    = rdata;
            tick();
            cyc++;
        end
        rready = 1'b0;
        check("r_beats", beats, len + 1);
        check("r_first_latency", first, 2);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_awready", awready, 0);
        check("rst_arready", arready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_rdata", rdata, 0);
        check("rst_resp", {bresp, rresp}, 0);
        check("rst_ids", {bid, rid}, 0);
        aresetn = 1'b1;
        tick();
        check("awready_after_rst", awready, 1);
        check("arready_after_rst", arready, 1);

        // 16-beat write and read-back at 0x100
        for (int i = 0; i < 16; i++) begin
            wdata_buf[i] = 64'h0101010101010101 * 64'(i + 1);
            wstrb_buf[i] = 8'hFF;
        end
        write_burst(32'h100, 15, 16, 2'b01, 3'd3, 1'b1, 1'b0);
        read_burst(32'h100, 15, 3'd3, 2'b01, 1'b1, 1'b0, 0);

        // Strobe merge on word 0
        wdata_buf[0] = '1; wstrb_buf[0] = 8'hFF;
        write_burst(32'h0, 0, 1, 2'b01, 3'd3, 1'b0, 1'b0);
        wdata_buf[0] = '0; wstrb_buf[0] = 8'h0F;
        write_burst(32'h0, 0, 1, 2'b01, 3'd3, 1'b0, 1'b0);
        check("strobe_model", model[0], 64'hFFFFFFFF00000000);
        read_burst(32'h0, 0, 3'd3, 2'b01, 1'b0, 1'b0, 0);

        // 256-beat write with WVALID gaps, 256-beat read with RREADY one cycle in three
        for (int i = 0; i < 256; i++) begin
            wdata_buf[i] = {$urandom, $urandom};
            wstrb_buf[i] = (i % 4 == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
        end
        write_burst(32'h400, 255, 256, 2'b01, 3'd3, 1'b0, 1'b1);
        read_burst(32'h400, 255, 3'd3, 2'b01, 1'b0, 1'b1, 0);

        // Protocol errors
        for (int i = 0; i < 4; i++) begin
            wdata_buf[i] = {$urandom, $urandom};
            wstrb_buf[i] = 8'hFF;
        end
        write_burst(32'h800, 3, 2, 2'b01, 3'd3, 1'b1, 1'b0);
        write_burst(32'h100, 3, 4, 2'b00, 3'd3, 1'b0, 1'b0);
        read_burst(32'h100, 3, 3'd3, 2'b01, 1'b0, 1'b0, 0);
        read_burst(32'h100, 3, 3'd2, 2'b01, 1'b1, 1'b0, 0);

        // Word index wraps from 1023 to 0
        for (int i = 0; i < 4; i++) begin
            wdata_buf[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
            wstrb_buf[i] = 8'hFF;
        end
        write_burst(32'h1FF0, 3, 4, 2'b01, 3'd3, 1'b1, 1'b0);
        check("wrap_model_w0", model[0], 64'hA5A5_0000_0000_0002);
        read_burst(32'h1FF0, 3, 3'd3, 2'b01, 1'b1, 1'b0, 0);
        read_burst(32'h0, 1, 3'd3, 2'b01, 1'b0, 1'b0, 0);

        // Reset during beat 5 of a 16-beat read, then a clean read
        read_burst(32'h100, 15, 3'd3, 2'b01, 1'b1, 1'b0, 4);
        repeat (2) tick();
        check("rst_mid_arready", arready, 0);
        check("rst_mid_bvalid", bvalid, 0);
        aresetn = 1'b1;
        tick();
        check("arready_after_mid_rst", arready, 1);
        read_burst(32'h100, 15, 3'd3, 2'b01, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
